// File: rtl/xz_fault_monitor.sv
// rtl/xz_fault_monitor.sv - X/Z fault monitor with consecutive-unknown FSM and known-sample forwarding
module xz_fault_monitor #(
    parameter int FAULT_THRESH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic       all_known,
    input  logic       has_unknown,
    input  logic [7:0] bus_if_known,
    input  logic       clear_fault,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       fault,
    output logic [3:0] run_len,
    output logic [7:0] err_count,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    localparam logic [3:0] THRESH = 4'(FAULT_THRESH);

    state_t     state;
    state_t     state_next;
    logic [3:0] run_next;

    // Inconsistent flag pairs are treated as unknown so a broken checker never looks healthy.
    logic sample_unknown;
    logic sample_known;
    logic fwd_cand;
    logic load;
    logic drop;

    assign sample_unknown = sample_valid & (has_unknown | ~all_known);
    assign sample_known   = sample_valid & ~(has_unknown | ~all_known);
    assign fwd_cand       = sample_known & (state != ST_FAULT);
    assign load           = fwd_cand & (~out_valid | out_ready);
    assign drop           = fwd_cand & out_valid & ~out_ready;

    assign fault = (state == ST_FAULT);

    // State and run-length register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_OK;
            run_len <= 4'd0;
        end else begin
            state   <= state_next;
            run_len <= run_next;
        end
    end

    // Next-state and run-length: clear wins, FAULT is sticky until cleared.
    always_comb begin
        state_next = state;
        run_next   = run_len;
        if (clear_fault) begin
            state_next = ST_OK;
            run_next   = 4'd0;
        end else begin
            case (state)
                ST_OK: begin
                    if (sample_unknown) begin
                        run_next   = 4'd1;
                        state_next = (THRESH == 4'd1) ? ST_FAULT : ST_SUSPECT;
                    end else if (sample_known) begin
                        run_next = 4'd0;
                    end
                end
                ST_SUSPECT: begin
                    if (sample_unknown) begin
                        run_next = 4'(run_len + 4'd1);
                        if (4'(run_len + 4'd1) == THRESH) begin
                            state_next = ST_FAULT;
                        end
                    end else if (sample_known) begin
                        run_next   = 4'd0;
                        state_next = ST_OK;
                    end
                end
                ST_FAULT: begin
                    if (sample_unknown && run_len != 4'd15) begin
                        run_next = 4'(run_len + 4'd1);
                    end
                end
                default: begin
                    state_next = ST_OK;
                    run_next   = 4'd0;
                end
            endcase
        end
    end

    // Saturating error counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'd0;
            overrun   <= 1'b0;
        end else if (clear_fault) begin
            err_count <= 8'd0;
            overrun   <= 1'b0;
        end else begin
            if (sample_unknown && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    // Output register: a new load beats a same-cycle consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= bus_if_known;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
